// File: rtl/instr_feeder.sv
// Program sequencer that feeds a 16-word instruction memory to a processor
// over a Run/Done handshake, with an mvi immediate phase and a Done watchdog.
module instr_feeder #(
   parameter int WD_LIMIT   = 15,
   parameter int PROG_DEPTH = 16
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Start,
   input  logic        Load,
   input  logic [3:0]  LoadAddr,
   input  logic [15:0] LoadData,
   input  logic [4:0]  ProgLen,
   input  logic        Done,
   output logic        Run,
   output logic [15:0] DIN,
   output logic [3:0]  PC,
   output logic        Busy,
   output logic        Finished,
   output logic        Error
);

   localparam int WDW = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(WD_LIMIT);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_IMM   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_NEXT  = 3'd4,
      ST_FIN   = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   state_t          state_r, state_s;
   logic [3:0]      pc_r, pc_s;
   logic [WDW-1:0]  wd_r, wd_s, wd_inc_s;
   logic            mvi_r, mvi_s;
   logic [15:0]     din_r, din_s;
   logic            run_r, busy_r, fin_r, err_r;
   logic            start_q_r;
   logic [15:0]     mem_r [PROG_DEPTH];

   logic            start_edge_s;
   logic            we_s;
   logic [4:0]      pl_eff_s;
   logic [4:0]      pc_inc_s;
   logic [4:0]      pc_adv_s;
   logic            is_mvi_s;
   logic [15:0]     issue_word_s;

   assign start_edge_s = Start & ~start_q_r;
   assign we_s         = Load & ((state_r == ST_IDLE) || (state_r == ST_FIN) || (state_r == ST_ERR));
   // Lengths above 16 are clamped so PC can never wrap while executing.
   assign pl_eff_s     = (ProgLen > 5'd16) ? 5'd16 : ProgLen;
   assign pc_inc_s     = {1'b0, pc_r} + 5'd1;
   assign pc_adv_s     = {1'b0, pc_r} + (mvi_r ? 5'd2 : 5'd1);
   assign is_mvi_s     = (mem_r[pc_r][8:6] == 3'b001);
   assign wd_inc_s     = wd_r + {{(WDW-1){1'b0}}, 1'b1};

   // Next-state, PC, watchdog and mvi-flag logic.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      wd_s    = wd_r;
      mvi_s   = mvi_r;
      case (state_r)
         ST_IDLE, ST_FIN: begin
            if (start_edge_s) begin
               if (pl_eff_s != 5'd0) begin
                  state_s = ST_ISSUE;
                  pc_s    = 4'd0;
               end else begin
                  state_s = ST_FIN;
               end
            end else begin
               state_s = state_r;
            end
         end
         ST_ISSUE: begin
            mvi_s = is_mvi_s;
            wd_s  = {WDW{1'b0}};
            if (is_mvi_s) begin
               if (pc_inc_s < pl_eff_s) begin
                  state_s = ST_IMM;
               end else begin
                  state_s = ST_ERR;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_IMM: begin
            state_s = ST_WAIT;
            wd_s    = {WDW{1'b0}};
         end
         ST_WAIT: begin
            if (Done) begin
               state_s = ST_NEXT;
            end else if (wd_inc_s == WD_MAX) begin
               state_s = ST_ERR;
            end else begin
               wd_s = wd_inc_s;
            end
         end
         ST_NEXT: begin
            if (pc_adv_s >= pl_eff_s) begin
               state_s = ST_FIN;
            end else begin
               state_s = ST_ISSUE;
               pc_s    = pc_adv_s[3:0];
            end
         end
         ST_ERR: begin
            if (start_edge_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_ERR;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Word presented on ISSUE, forwarding a same-cycle load to the new PC.
   always_comb begin
      issue_word_s = mem_r[pc_s];
      if (we_s && (LoadAddr == pc_s)) begin
         issue_word_s = LoadData;
      end else begin
         issue_word_s = mem_r[pc_s];
      end
   end

   // DIN value for the upcoming state.
   always_comb begin
      din_s = din_r;
      case (state_s)
         ST_ISSUE:         din_s = issue_word_s;
         ST_IMM:           din_s = mem_r[pc_s + 4'd1];
         ST_WAIT, ST_NEXT: din_s = din_r;
         default:          din_s = 16'h0000;
      endcase
   end

   // Control state and registered outputs.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r   <= ST_IDLE;
         pc_r      <= 4'd0;
         wd_r      <= {WDW{1'b0}};
         mvi_r     <= 1'b0;
         din_r     <= 16'h0000;
         run_r     <= 1'b0;
         busy_r    <= 1'b0;
         fin_r     <= 1'b0;
         err_r     <= 1'b0;
         start_q_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         wd_r      <= wd_s;
         mvi_r     <= mvi_s;
         din_r     <= din_s;
         run_r     <= (state_s == ST_ISSUE);
         busy_r    <= (state_s == ST_ISSUE) || (state_s == ST_IMM) ||
                      (state_s == ST_WAIT)  || (state_s == ST_NEXT);
         fin_r     <= (state_s == ST_FIN);
         err_r     <= (state_s == ST_ERR);
         start_q_r <= Start;
      end
   end

   // Program memory, writable only while the sequencer is not executing.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < PROG_DEPTH; i++) begin
            mem_r[i] <= 16'h0000;
         end
      end else if (we_s) begin
         mem_r[LoadAddr] <= LoadData;
      end
   end

   assign Run      = run_r;
   assign DIN      = din_r;
   assign PC       = pc_r;
   assign Busy     = busy_r;
   assign Finished = fin_r;
   assign Error    = err_r;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed self-checking bench for instr_feeder: handshake, mvi, watchdog,
// busy lockout, asynchronous reset and same-cycle load/start forwarding.
module tb_instr_feeder;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        Start;
   logic        Load;
   logic [3:0]  LoadAddr;
   logic [15:0] LoadData;
   logic [4:0]  ProgLen;
   logic        Done;
   logic        Run;
   logic [15:0] DIN;
   logic [3:0]  PC;
   logic        Busy;
   logic        Finished;
   logic        Error;

   int n_cmp = 0;
   int n_bad = 0;
   int run_cnt = 0;
   int run_base;

   instr_feeder #(.WD_LIMIT(15), .PROG_DEPTH(16)) dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Load(Load),
      .LoadAddr(LoadAddr), .LoadData(LoadData), .ProgLen(ProgLen), .Done(Done),
      .Run(Run), .DIN(DIN), .PC(PC), .Busy(Busy), .Finished(Finished), .Error(Error)
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock) begin
      if (Run) run_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [15:0] d);
      Load = 1'b1; LoadAddr = a; LoadData = d;
      tick();
      Load = 1'b0;
   endtask

   initial begin
      Resetn = 1'b0; Start = 1'b0; Load = 1'b0; LoadAddr = 4'd0;
      LoadData = 16'h0000; ProgLen = 5'd0; Done = 1'b0;
      #12;
      chk("rst_run", Run, 1'b0);
      chk("rst_din", DIN, 16'h0000);
      chk("rst_pc", PC, 4'd0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_fin", Finished, 1'b0);
      chk("rst_err", Error, 1'b0);
      tick();
      Resetn = 1'b1;
      tick();

      // single mv R0,R0
      load_word(4'd0, 16'h0000);
      ProgLen = 5'd1;
      Start = 1'b1; tick();
      chk("s1_run", Run, 1'b1);
      chk("s1_din", DIN, 16'h0000);
      chk("s1_busy", Busy, 1'b1);
      Start = 1'b0; tick();
      chk("s1_wait_run", Run, 1'b0);
      tick();
      Done = 1'b1; tick();
      chk("s1_next_busy", Busy, 1'b1);
      chk("s1_next_fin", Finished, 1'b0);
      Done = 1'b0; tick();
      chk("s1_fin", Finished, 1'b1);
      chk("s1_fin_busy", Busy, 1'b0);
      chk("s1_fin_pc", PC, 4'd0);

      // mvi R1,#5 loaded while in FIN
      load_word(4'd0, 16'h0048);
      load_word(4'd1, 16'h0005);
      ProgLen = 5'd2;
      run_base = run_cnt;
      Start = 1'b1; tick();
      chk("s2_issue_run", Run, 1'b1);
      chk("s2_issue_din", DIN, 16'h0048);
      Start = 1'b0; tick();
      chk("s2_imm_run", Run, 1'b0);
      chk("s2_imm_din", DIN, 16'h0005);
      tick();
      chk("s2_wait_din", DIN, 16'h0005);
      tick();
      chk("s2_wait_din2", DIN, 16'h0005);
      Done = 1'b1; tick();
      Done = 1'b0; tick();
      chk("s2_fin", Finished, 1'b1);
      chk("s2_fin_pc", PC, 4'd0);
      chk("s2_run_pulses", run_cnt - run_base, 1);

      // mvi in the last word
      ProgLen = 5'd1;
      Start = 1'b1; tick();
      chk("s3_issue_run", Run, 1'b1);
      Start = 1'b0; tick();
      chk("s3_err", Error, 1'b1);
      chk("s3_err_pc", PC, 4'd0);
      chk("s3_err_din", DIN, 16'h0000);
      chk("s3_err_run", Run, 1'b0);
      Start = 1'b1; tick();
      chk("s3_clr_err", Error, 1'b0);
      chk("s3_idle_busy", Busy, 1'b0);
      Start = 1'b0; tick();

      // watchdog: WAIT entered, no Done
      load_word(4'd0, 16'h0000);
      ProgLen = 5'd3;
      Start = 1'b1; tick();
      Start = 1'b0; tick();
      repeat (14) tick();
      chk("s4_wd_pre_err", Error, 1'b0);
      chk("s4_wd_pre_busy", Busy, 1'b1);
      tick();
      chk("s4_wd_err", Error, 1'b1);
      chk("s4_wd_pc", PC, 4'd0);
      Start = 1'b1; tick();
      Start = 1'b0; tick();

      // load and start edge while busy are ignored
      load_word(4'd1, 16'h1111);
      load_word(4'd2, 16'h2222);
      Start = 1'b1; tick();
      Start = 1'b0; tick();
      Load = 1'b1; LoadAddr = 4'd1; LoadData = 16'hBEEF; Start = 1'b1;
      tick();
      Load = 1'b0;
      chk("s5_busy", Busy, 1'b1);
      chk("s5_run", Run, 1'b0);
      chk("s5_pc", PC, 4'd0);
      Done = 1'b1; tick();
      Done = 1'b0; tick();
      chk("s5_issue1_run", Run, 1'b1);
      chk("s5_issue1_pc", PC, 4'd1);
      chk("s5_issue1_din", DIN, 16'h1111);
      tick();
      chk("s5_wait_din", DIN, 16'h1111);

      // asynchronous reset during WAIT
      #1 Resetn = 1'b0;
      #1;
      chk("s6_run", Run, 1'b0);
      chk("s6_din", DIN, 16'h0000);
      chk("s6_pc", PC, 4'd0);
      chk("s6_busy", Busy, 1'b0);
      chk("s6_fin", Finished, 1'b0);
      chk("s6_err", Error, 1'b0);
      Start = 1'b0;
      tick();
      Resetn = 1'b1;
      tick();
      tick();
      chk("s6_idle_busy", Busy, 1'b0);
      chk("s6_idle_run", Run, 1'b0);
      Start = 1'b1; tick();
      chk("s6_restart_run", Run, 1'b1);
      Start = 1'b0; tick();
      Done = 1'b1; tick();
      Done = 1'b0; tick();
      chk("s6_pc1", PC, 4'd1);
      chk("s6_mem1_cleared", DIN, 16'h0000);

      // same-cycle load and start, then ProgLen==0 start
      #1 Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
      tick();
      ProgLen = 5'd1;
      Load = 1'b1; LoadAddr = 4'd0; LoadData = 16'h0C03; Start = 1'b1;
      tick();
      Load = 1'b0;
      chk("s7_fwd_run", Run, 1'b1);
      chk("s7_fwd_din", DIN, 16'h0C03);
      Start = 1'b0; tick();
      Done = 1'b1; tick();
      Done = 1'b0; tick();
      chk("s7_fin", Finished, 1'b1);
      ProgLen = 5'd0;
      Start = 1'b1; tick();
      chk("s7_len0_fin", Finished, 1'b1);
      chk("s7_len0_busy", Busy, 1'b0);
      chk("s7_len0_run", Run, 1'b0);
      Start = 1'b0; tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 Parameters SHALL be:
- WD_LIMIT, default 15: Done-watchdog limit, in cycles spent in WAIT.
- PROG_DEPTH, default 16: number of program memory words; fixed at 16.

REQ-002 Ports SHALL be:
- Clock  in  1  single system clock; all state on its rising edge.
- Resetn  in  1  reset, asynchronous and active-low.
- Start  in  1  level input (switch); its rising edge starts a program.
- Load  in  1  program-memory write enable.
- LoadAddr  in  4  write address.
- LoadData  in  16  write data.
- ProgLen  in  5  program length in words, 0..16.
- Done  in  1  processor instruction-complete.
- Run  out  1  one-cycle instruction-issue strobe to the processor.
- DIN  out  16  instruction/immediate word to the processor.
- PC  out  4  address of the current instruction.
- Busy  out  1  high in ISSUE/IMM/WAIT/NEXT.
- Finished  out  1  high in FIN.
- Error  out  1  high in ERR.

Function
REQ-003 The block SHALL drive the initiator side of the processor Run/Done handshake from an internal 16x16 program memory.
REQ-004 Start SHALL be registered once; start_edge = Start & ~Start_q, one cycle wide.
REQ-005 A write with Load=1 SHALL store LoadData at LoadAddr only in IDLE/FIN/ERR; Load SHALL be ignored while Busy=1.
REQ-006 States SHALL be IDLE, ISSUE, IMM, WAIT, NEXT, FIN, ERR.
REQ-007 IDLE transitions:
- start_edge with ProgLen!=0: go to ISSUE, PC=0.
- start_edge with ProgLen==0: go to FIN.
REQ-008 ISSUE SHALL last exactly one cycle with Run=1 and DIN=mem[PC]. Next state:
- opcode (mem[PC][8:6]) is 3'b001 (mvi) and PC+1<ProgLen: go to IMM.
- opcode is mvi and PC+1>=ProgLen: go to ERR.
- otherwise: go to WAIT.
REQ-009 IMM SHALL last one cycle with Run=0 and DIN=mem[PC+1], then go to WAIT.
REQ-010 In WAIT, Run SHALL be 0 and DIN SHALL hold its last value.
REQ-011 In WAIT, Done=1 SHALL go to NEXT; otherwise the watchdog SHALL increment.
REQ-012 The watchdog SHALL be cleared on WAIT entry; when it reaches WD_LIMIT without Done, the block SHALL go to ERR.
REQ-013 Done SHALL be ignored in ISSUE, IMM, IDLE, FIN and ERR.
REQ-014 NEXT SHALL advance PC by 2 after an mvi and by 1 otherwise.
REQ-015 The advance SHALL be computed in 5 bits; if the new value is >=ProgLen the block SHALL go to FIN, else to ISSUE.
REQ-016 PC SHALL never wrap past 15 while executing.
REQ-017 FIN: Finished=1, PC holds, DIN=0; start_edge SHALL restart at ISSUE with PC=0, or go to FIN if ProgLen==0.
REQ-018 ERR: Error=1, Run=0, DIN=0, PC holds the failing address; start_edge SHALL clear Error and go to IDLE.
REQ-019 start_edge while Busy SHALL be ignored.
REQ-020 Load and start_edge in the same IDLE cycle SHALL both take effect; ISSUE SHALL read the newly written word.
REQ-021 Mid-program, ProgLen changes SHALL be sampled only in ISSUE and NEXT.
REQ-022 Issue latency from start_edge SHALL be 1 cycle: Run=1 in the cycle after the edge is detected.

Reset
REQ-023 Resetn=0 SHALL asynchronously force:
- state IDLE;
- PC=0, Run=0, DIN=0;
- Busy=0, Finished=0, Error=0;
- watchdog=0, Start_q=0;
- all memory words=0.
REQ-024 Reset asserted mid-handshake SHALL abort immediately: Run=0 in the same cycle, with no further issue after release until a new start_edge.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Load mem0=0x0000 (mv R0,R0), ProgLen=1, Start edge -> Run=1 for one cycle with DIN=0x0000; Done after 2 cycles -> FIN, Finished=1, PC=0.
- Load mem0=0x0048 (mvi R1), mem1=0x0005, ProgLen=2 -> ISSUE DIN=0x0048, then DIN=0x0005 held through WAIT; Done -> FIN, one Run pulse total.
- mvi at last word (ProgLen=1, mem0=0x0048) -> ERR after ISSUE, Error=1, PC=0; Start edge -> IDLE, Error=0.
- ProgLen=3, Done never asserted -> ERR exactly WD_LIMIT cycles after WAIT entry, PC=0.
- Load pulse and second Start edge while Busy -> memory and state unchanged.
- Resetn=0 during WAIT of a 3-word program -> all outputs 0 asynchronously; after release, stays IDLE until a Start edge; memory reads back 0.
